// File: rtl/bcd_pkg.sv
// Shared widths, digit vector type and active-low 7-segment glyph table for the
// keypad entry decoder.
package bcd_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGITS_W   = BCD_W * NUM_DIGITS;
    localparam int unsigned SEG_W      = 7;

    typedef logic [DIGITS_W-1:0] digits_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Active-low glyphs, bit 0 = segment a, bit 6 = segment g.
    localparam logic [SEG_W-1:0] SEG_LUT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder with a blanking override.
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);

    // Codes above 9 never reach the display; they decode to all-off for safety.
    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (bcd <= BCD_W'(9))) begin
            seg = SEG_LUT[bcd];
        end
    end

endmodule

// File: rtl/bcd_entry_decoder.sv
// Keypad BCD receiver: synchronises the strobe, shifts digits in MM:SS style and
// scans a multiplexed 7-segment display. Define BCD_ENTRY_BLANK_EN for leading-zero blanking.
module bcd_entry_decoder
    import bcd_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  bcd,
    input  logic        loadn,
    input  logic        clear,
    input  logic        hold,
    output logic [15:0] digits,
    output logic        zero,
    output logic        loaded,
    output logic        err,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [BCD_W-1:0] bcd1_q, bcd1_d, bcd2_q, bcd2_d;
    digits_t          digits_q, digits_d;
    logic             loaded_q, loaded_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [SEG_W-1:0] seg_q, seg_d;

    logic             capture_c;
    logic [BCD_W-1:0] cur_digit_c;
    logic             blank_c;
    logic [SEG_W-1:0] seg_c;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            s3_q     <= 1'b1;
            bcd1_q   <= '0;
            bcd2_q   <= '0;
            digits_q <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            an_q     <= 4'b1110;
            seg_q    <= SEG_LUT[0];
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            bcd1_q   <= bcd1_d;
            bcd2_q   <= bcd2_d;
            digits_q <= digits_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    // Strobe and code share the same two-stage pipeline so bcd2_q is aligned with s2_q.
    always_comb begin
        s1_d      = loadn;
        s2_d      = s1_q;
        s3_d      = s2_q;
        bcd1_d    = bcd;
        bcd2_d    = bcd1_q;
        capture_c = s3_q & ~s2_q;
    end

    // Entry register: clear wins over everything, hold only blocks key loads.
    always_comb begin
        digits_d = digits_q;
        loaded_d = 1'b0;
        err_d    = 1'b0;
        if (clear) begin
            digits_d = '0;
        end else if (capture_c && !hold) begin
            if (bcd2_q > BCD_W'(9)) begin
                err_d = 1'b1;
            end else begin
                digits_d = {digits_q[DIGITS_W-BCD_W-1:0], bcd2_q};
                loaded_d = 1'b1;
            end
        end
    end

    // Refresh counter and scan index.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Scan mux: idx 0 = sec_units through idx 3 = min_tens.
    always_comb begin
        cur_digit_c = digits_q[3:0];
        blank_c     = 1'b0;
        case (idx_q)
            2'd0: cur_digit_c = digits_q[3:0];
            2'd1: cur_digit_c = digits_q[7:4];
            2'd2: cur_digit_c = digits_q[11:8];
            default: cur_digit_c = digits_q[15:12];
        endcase
`ifdef BCD_ENTRY_BLANK_EN
        case (idx_q)
            2'd0: blank_c = 1'b0;
            2'd1: blank_c = (digits_q[15:4] == 12'd0);
            2'd2: blank_c = (digits_q[15:8] == 8'd0);
            default: blank_c = (digits_q[15:12] == 4'd0);
        endcase
`endif
    end

    bcd_to_seg7 u_seg (
        .bcd   (cur_digit_c),
        .blank (blank_c),
        .seg   (seg_c)
    );

    always_comb begin
        an_d  = ~(4'd1 << idx_q);
        seg_d = seg_c;
    end

    assign digits = digits_q;
    assign zero   = (digits_q == '0);
    assign loaded = loaded_q;
    assign err    = err_q;
    assign seg    = seg_q;
    assign an     = an_q;

endmodule

// File: tb/tb_bcd_entry_decoder.sv
// Directed self-checking bench for bcd_entry_decoder with REFRESH_DIV=4.
module tb_bcd_entry_decoder;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  bcd;
    logic        loadn;
    logic        clear;
    logic        hold;
    logic [15:0] digits;
    logic        zero;
    logic        loaded;
    logic        err;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int fails  = 0;
    logic [15:0] exp_dig;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] GB = 7'b1111111;
`ifdef BCD_ENTRY_BLANK_EN
    localparam logic [6:0] GL = GB;
`else
    localparam logic [6:0] GL = G0;
`endif

    bcd_entry_decoder #(.REFRESH_DIV(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bcd    (bcd),
        .loadn  (loadn),
        .clear  (clear),
        .hold   (hold),
        .digits (digits),
        .zero   (zero),
        .loaded (loaded),
        .err    (err),
        .seg    (seg),
        .an     (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One keypad strobe: 5 cycles low, 5 high; optional clear timed onto the capture cycle.
    task automatic strobe(input logic [3:0] code, input logic [15:0] new_dig,
                          input logic exp_ld, input logic exp_er, input logic clr_at_event);
        logic [15:0] old_dig;
        old_dig = exp_dig;
        @(negedge clk);
        bcd   = code;
        loadn = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i < 3) begin
                check("pre_digits", digits, old_dig);
                check("pre_loaded", 16'(loaded), 16'd0);
            end else if (i == 3) begin
                check("cap_digits", digits, new_dig);
                check("cap_loaded", 16'(loaded), 16'(exp_ld));
                check("cap_err", 16'(err), 16'(exp_er));
                check("cap_zero", 16'(zero), 16'(new_dig == 16'd0));
            end else begin
                check("post_loaded", 16'(loaded), 16'd0);
                check("post_err", 16'(err), 16'd0);
            end
            if (clr_at_event && i == 2) clear = 1'b1;
            if (i == 3) clear = 1'b0;
        end
        loadn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_loaded", 16'(loaded), 16'd0);
        end
        exp_dig = new_dig;
    endtask

    task automatic scan_check(input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        repeat (16) begin
            @(negedge clk);
            case (an)
                4'b1110: check("scan_seg0", 16'(seg), 16'(e0));
                4'b1101: check("scan_seg1", 16'(seg), 16'(e1));
                4'b1011: check("scan_seg2", 16'(seg), 16'(e2));
                4'b0111: check("scan_seg3", 16'(seg), 16'(e3));
                default: check("scan_an_onehot", 16'(an), 16'hFFFF);
            endcase
        end
    endtask

    initial begin
        logic [3:0] an_exp;
        resetn  = 1'b0;
        bcd     = 4'd0;
        loadn   = 1'b1;
        clear   = 1'b0;
        hold    = 1'b0;
        exp_dig = 16'h0000;
        #23;
        check("rst_digits", digits, 16'h0000);
        check("rst_zero", 16'(zero), 16'd1);
        check("rst_an", 16'(an), 16'(4'b1110));
        check("rst_seg", 16'(seg), 16'(G0));
        check("rst_loaded", 16'(loaded), 16'd0);
        check("rst_err", 16'(err), 16'd0);

        @(negedge clk);
        resetn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            case (((k - 1) / 4) % 4)
                0: an_exp = 4'b1110;
                1: an_exp = 4'b1101;
                2: an_exp = 4'b1011;
                default: an_exp = 4'b0111;
            endcase
            check("init_an", 16'(an), 16'(an_exp));
            check("init_seg", 16'(seg), 16'(an_exp == 4'b1110 ? G0 : GL));
        end

        strobe(4'd1, 16'h0001, 1'b1, 1'b0, 1'b0);
        strobe(4'd3, 16'h0013, 1'b1, 1'b0, 1'b0);
        strobe(4'd0, 16'h0130, 1'b1, 1'b0, 1'b0);
        check("entry_zero", 16'(zero), 16'd0);

        strobe(4'hC, 16'h0130, 1'b0, 1'b1, 1'b0);

        strobe(4'd1, 16'h1301, 1'b1, 1'b0, 1'b0);
        strobe(4'd2, 16'h3012, 1'b1, 1'b0, 1'b0);
        strobe(4'd3, 16'h0123, 1'b1, 1'b0, 1'b0);
        strobe(4'd4, 16'h1234, 1'b1, 1'b0, 1'b0);
        strobe(4'd5, 16'h2345, 1'b1, 1'b0, 1'b0);
        check("shift_out", digits, 16'h2345);

        hold = 1'b1;
        strobe(4'd7, 16'h2345, 1'b0, 1'b0, 1'b0);
        hold = 1'b0;
        strobe(4'd8, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("clear_zero", 16'(zero), 16'd1);

        strobe(4'd4, 16'h0004, 1'b1, 1'b0, 1'b0);
        strobe(4'd5, 16'h0045, 1'b1, 1'b0, 1'b0);
        scan_check(G5, G4, GL, GL);

        #2;
        resetn = 1'b0;
        #1;
        check("midrst_digits", digits, 16'h0000);
        check("midrst_an", 16'(an), 16'(4'b1110));
        check("midrst_seg", 16'(seg), 16'(G0));
        check("midrst_zero", 16'(zero), 16'd1);
        check("midrst_loaded", 16'(loaded), 16'd0);
        check("midrst_err", 16'(err), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
